rv_instr_evmon: RTL and testbench

- Event monitor that converts the RV32 core's one-hot decoded-instruction flags into registered, single-cycle event pulses, one per instruction class.
- Events are qualified by the core's next-instruction strobe.
- Sits beside the core in the system wrapper; its ev_* outputs are hierarchically probed by the top level (e.g. ev_add) for tracing/coverage.
- Also provides aggregate class events and a retired-instruction counter.

---
 rtl/rv_instr_evmon_pkg.sv | 59 +++++
 rtl/rv_instr_evmon.sv | 246 ++++++++++++++++++++++++
 tb/tb_rv_instr_evmon.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_instr_evmon_pkg.sv
// Shared definitions for the RV32 instruction event monitor: event indices
// in port order and the per-class membership masks over the flag vector.
package rv_instr_evmon_pkg;

  localparam int EV_N = 49;

  typedef enum logic [5:0] {
    IDX_LUI, IDX_AUIPC, IDX_JAL, IDX_JALR,
    IDX_BEQ, IDX_BNE, IDX_BLT, IDX_BGE, IDX_BLTU, IDX_BGEU,
    IDX_LB, IDX_LH, IDX_LW, IDX_LBU, IDX_LHU,
    IDX_SB, IDX_SH, IDX_SW,
    IDX_ADDI, IDX_SLTI, IDX_SLTIU, IDX_XORI, IDX_ORI, IDX_ANDI,
    IDX_SLLI, IDX_SRLI, IDX_SRAI,
    IDX_ADD, IDX_SUB, IDX_SLL, IDX_SLT, IDX_SLTU, IDX_XOR, IDX_SRL, IDX_SRA,
    IDX_OR, IDX_AND,
    IDX_RDCYCLE, IDX_RDCYCLEH, IDX_RDINSTR, IDX_RDINSTRH,
    IDX_ECALL_EBREAK,
    IDX_GETQ, IDX_SETQ, IDX_RETIRQ, IDX_MASKIRQ, IDX_WAITIRQ, IDX_TIMER,
    IDX_TRAP
  } ev_idx_e;

  typedef logic [EV_N-1:0] ev_vec_t;

  function automatic ev_vec_t ev_bit(input ev_idx_e idx);
    ev_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  localparam ev_vec_t LOAD_MASK =
    ev_bit(IDX_LB) | ev_bit(IDX_LH) | ev_bit(IDX_LW) | ev_bit(IDX_LBU) | ev_bit(IDX_LHU);

  localparam ev_vec_t STORE_MASK =
    ev_bit(IDX_SB) | ev_bit(IDX_SH) | ev_bit(IDX_SW);

  localparam ev_vec_t BRANCH_MASK =
    ev_bit(IDX_BEQ) | ev_bit(IDX_BNE) | ev_bit(IDX_BLT) |
    ev_bit(IDX_BGE) | ev_bit(IDX_BLTU) | ev_bit(IDX_BGEU);

  localparam ev_vec_t JUMP_MASK =
    ev_bit(IDX_JAL) | ev_bit(IDX_JALR);

  localparam ev_vec_t ALU_MASK =
    ev_bit(IDX_LUI)  | ev_bit(IDX_AUIPC) | ev_bit(IDX_ADDI) | ev_bit(IDX_SLTI) |
    ev_bit(IDX_SLTIU) | ev_bit(IDX_XORI) | ev_bit(IDX_ORI)  | ev_bit(IDX_ANDI) |
    ev_bit(IDX_SLLI) | ev_bit(IDX_SRLI)  | ev_bit(IDX_SRAI) | ev_bit(IDX_ADD)  |
    ev_bit(IDX_SUB)  | ev_bit(IDX_SLL)   | ev_bit(IDX_SLT)  | ev_bit(IDX_SLTU) |
    ev_bit(IDX_XOR)  | ev_bit(IDX_SRL)   | ev_bit(IDX_SRA)  | ev_bit(IDX_OR)   |
    ev_bit(IDX_AND);

  localparam ev_vec_t CSR_MASK =
    ev_bit(IDX_RDCYCLE) | ev_bit(IDX_RDCYCLEH) | ev_bit(IDX_RDINSTR) | ev_bit(IDX_RDINSTRH);

  localparam ev_vec_t IRQOP_MASK =
    ev_bit(IDX_GETQ) | ev_bit(IDX_SETQ) | ev_bit(IDX_RETIRQ) |
    ev_bit(IDX_MASKIRQ) | ev_bit(IDX_WAITIRQ) | ev_bit(IDX_TIMER);

endpackage

// File: rtl/rv_instr_evmon.sv
// Registered single-cycle event pulses from the core's decoded-instruction
// flags, qualified by i_dbg_next. Optional ev_discont output: EVMON_DISCONT_EN.
module rv_instr_evmon
  import rv_instr_evmon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_instr_lui,   input  logic i_instr_auipc,
  input  logic i_instr_jal,   input  logic i_instr_jalr,
  input  logic i_instr_beq,   input  logic i_instr_bne,
  input  logic i_instr_blt,   input  logic i_instr_bge,
  input  logic i_instr_bltu,  input  logic i_instr_bgeu,
  input  logic i_instr_lb,    input  logic i_instr_lh,
  input  logic i_instr_lw,    input  logic i_instr_lbu,
  input  logic i_instr_lhu,   input  logic i_instr_sb,
  input  logic i_instr_sh,    input  logic i_instr_sw,
  input  logic i_instr_addi,  input  logic i_instr_slti,
  input  logic i_instr_sltiu, input  logic i_instr_xori,
  input  logic i_instr_ori,   input  logic i_instr_andi,
  input  logic i_instr_slli,  input  logic i_instr_srli,
  input  logic i_instr_srai,  input  logic i_instr_add,
  input  logic i_instr_sub,   input  logic i_instr_sll,
  input  logic i_instr_slt,   input  logic i_instr_sltu,
  input  logic i_instr_xor,   input  logic i_instr_srl,
  input  logic i_instr_sra,   input  logic i_instr_or,
  input  logic i_instr_and,   input  logic i_instr_rdcycle,
  input  logic i_instr_rdcycleh, input logic i_instr_rdinstr,
  input  logic i_instr_rdinstrh, input logic i_instr_ecall_ebreak,
  input  logic i_instr_getq,  input  logic i_instr_setq,
  input  logic i_instr_retirq, input logic i_instr_maskirq,
  input  logic i_instr_waitirq, input logic i_instr_timer,
  input  logic i_instr_trap,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_next_pc,
  input  logic i_dbg_next,
  output logic ev_lui,   output logic ev_auipc,
  output logic ev_jal,   output logic ev_jalr,
  output logic ev_beq,   output logic ev_bne,
  output logic ev_blt,   output logic ev_bge,
  output logic ev_bltu,  output logic ev_bgeu,
  output logic ev_lb,    output logic ev_lh,
  output logic ev_lw,    output logic ev_lbu,
  output logic ev_lhu,   output logic ev_sb,
  output logic ev_sh,    output logic ev_sw,
  output logic ev_addi,  output logic ev_slti,
  output logic ev_sltiu, output logic ev_xori,
  output logic ev_ori,   output logic ev_andi,
  output logic ev_slli,  output logic ev_srli,
  output logic ev_srai,  output logic ev_add,
  output logic ev_sub,   output logic ev_sll,
  output logic ev_slt,   output logic ev_sltu,
  output logic ev_xor,   output logic ev_srl,
  output logic ev_sra,   output logic ev_or,
  output logic ev_and,   output logic ev_rdcycle,
  output logic ev_rdcycleh, output logic ev_rdinstr,
  output logic ev_rdinstrh, output logic ev_ecall_ebreak,
  output logic ev_getq,  output logic ev_setq,
  output logic ev_retirq, output logic ev_maskirq,
  output logic ev_waitirq, output logic ev_timer,
  output logic ev_trap,
  output logic ev_any,
  output logic ev_load,
  output logic ev_store,
  output logic ev_branch,
  output logic ev_jump,
  output logic ev_alu,
  output logic ev_csr,
  output logic ev_irqop,
`ifdef EVMON_DISCONT_EN
  output logic ev_discont,
`endif
  output logic [CNT_W-1:0] o_instret
);

  ev_vec_t w_flags;
  ev_vec_t w_qual;

  assign w_flags[IDX_LUI]          = i_instr_lui;
  assign w_flags[IDX_AUIPC]        = i_instr_auipc;
  assign w_flags[IDX_JAL]          = i_instr_jal;
  assign w_flags[IDX_JALR]         = i_instr_jalr;
  assign w_flags[IDX_BEQ]          = i_instr_beq;
  assign w_flags[IDX_BNE]          = i_instr_bne;
  assign w_flags[IDX_BLT]          = i_instr_blt;
  assign w_flags[IDX_BGE]          = i_instr_bge;
  assign w_flags[IDX_BLTU]         = i_instr_bltu;
  assign w_flags[IDX_BGEU]         = i_instr_bgeu;
  assign w_flags[IDX_LB]           = i_instr_lb;
  assign w_flags[IDX_LH]           = i_instr_lh;
  assign w_flags[IDX_LW]           = i_instr_lw;
  assign w_flags[IDX_LBU]          = i_instr_lbu;
  assign w_flags[IDX_LHU]          = i_instr_lhu;
  assign w_flags[IDX_SB]           = i_instr_sb;
  assign w_flags[IDX_SH]           = i_instr_sh;
  assign w_flags[IDX_SW]           = i_instr_sw;
  assign w_flags[IDX_ADDI]         = i_instr_addi;
  assign w_flags[IDX_SLTI]         = i_instr_slti;
  assign w_flags[IDX_SLTIU]        = i_instr_sltiu;
  assign w_flags[IDX_XORI]         = i_instr_xori;
  assign w_flags[IDX_ORI]          = i_instr_ori;
  assign w_flags[IDX_ANDI]         = i_instr_andi;
  assign w_flags[IDX_SLLI]         = i_instr_slli;
  assign w_flags[IDX_SRLI]         = i_instr_srli;
  assign w_flags[IDX_SRAI]         = i_instr_srai;
  assign w_flags[IDX_ADD]          = i_instr_add;
  assign w_flags[IDX_SUB]          = i_instr_sub;
  assign w_flags[IDX_SLL]          = i_instr_sll;
  assign w_flags[IDX_SLT]          = i_instr_slt;
  assign w_flags[IDX_SLTU]         = i_instr_sltu;
  assign w_flags[IDX_XOR]          = i_instr_xor;
  assign w_flags[IDX_SRL]          = i_instr_srl;
  assign w_flags[IDX_SRA]          = i_instr_sra;
  assign w_flags[IDX_OR]           = i_instr_or;
  assign w_flags[IDX_AND]          = i_instr_and;
  assign w_flags[IDX_RDCYCLE]      = i_instr_rdcycle;
  assign w_flags[IDX_RDCYCLEH]     = i_instr_rdcycleh;
  assign w_flags[IDX_RDINSTR]      = i_instr_rdinstr;
  assign w_flags[IDX_RDINSTRH]     = i_instr_rdinstrh;
  assign w_flags[IDX_ECALL_EBREAK] = i_instr_ecall_ebreak;
  assign w_flags[IDX_GETQ]         = i_instr_getq;
  assign w_flags[IDX_SETQ]         = i_instr_setq;
  assign w_flags[IDX_RETIRQ]       = i_instr_retirq;
  assign w_flags[IDX_MASKIRQ]      = i_instr_maskirq;
  assign w_flags[IDX_WAITIRQ]      = i_instr_waitirq;
  assign w_flags[IDX_TIMER]        = i_instr_timer;
  assign w_flags[IDX_TRAP]         = i_instr_trap;

  // Flags are don't-care unless the core is launching an instruction.
  assign w_qual = w_flags & {EV_N{i_dbg_next}};

  ev_vec_t          r_ev;
  logic             r_any;
  logic             r_load, r_store, r_branch, r_jump, r_alu, r_csr, r_irqop;
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ev      <= '0;
      r_any     <= 1'b0;
      r_load    <= 1'b0;
      r_store   <= 1'b0;
      r_branch  <= 1'b0;
      r_jump    <= 1'b0;
      r_alu     <= 1'b0;
      r_csr     <= 1'b0;
      r_irqop   <= 1'b0;
      r_instret <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values; the
      // counter reads its own old value with no ordering hazard.
      r_ev      <= w_qual;
      r_any     <= i_dbg_next;
      r_load    <= |(w_qual & LOAD_MASK);
      r_store   <= |(w_qual & STORE_MASK);
      r_branch  <= |(w_qual & BRANCH_MASK);
      r_jump    <= |(w_qual & JUMP_MASK);
      r_alu     <= |(w_qual & ALU_MASK);
      r_csr     <= |(w_qual & CSR_MASK);
      r_irqop   <= |(w_qual & IRQOP_MASK);
      if (i_dbg_next) r_instret <= r_instret + CNT_W'(1);
    end
  end

`ifdef EVMON_DISCONT_EN
  logic [31:0] w_pc_plus2;
  logic [31:0] w_pc_plus4;
  logic        r_discont;

  // Sequential fetch advances by 2 (compressed) or 4; anything else is a jump.
  assign w_pc_plus2 = i_pc + 32'd2;
  assign w_pc_plus4 = i_pc + 32'd4;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_discont <= 1'b0;
    else          r_discont <= i_dbg_next & (i_next_pc != w_pc_plus2) & (i_next_pc != w_pc_plus4);
  end

  assign ev_discont = r_discont;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{i_pc, i_next_pc};
`endif

  assign ev_lui          = r_ev[IDX_LUI];
  assign ev_auipc        = r_ev[IDX_AUIPC];
  assign ev_jal          = r_ev[IDX_JAL];
  assign ev_jalr         = r_ev[IDX_JALR];
  assign ev_beq          = r_ev[IDX_BEQ];
  assign ev_bne          = r_ev[IDX_BNE];
  assign ev_blt          = r_ev[IDX_BLT];
  assign ev_bge          = r_ev[IDX_BGE];
  assign ev_bltu         = r_ev[IDX_BLTU];
  assign ev_bgeu         = r_ev[IDX_BGEU];
  assign ev_lb           = r_ev[IDX_LB];
  assign ev_lh           = r_ev[IDX_LH];
  assign ev_lw           = r_ev[IDX_LW];
  assign ev_lbu          = r_ev[IDX_LBU];
  assign ev_lhu          = r_ev[IDX_LHU];
  assign ev_sb           = r_ev[IDX_SB];
  assign ev_sh           = r_ev[IDX_SH];
  assign ev_sw           = r_ev[IDX_SW];
  assign ev_addi         = r_ev[IDX_ADDI];
  assign ev_slti         = r_ev[IDX_SLTI];
  assign ev_sltiu        = r_ev[IDX_SLTIU];
  assign ev_xori         = r_ev[IDX_XORI];
  assign ev_ori          = r_ev[IDX_ORI];
  assign ev_andi         = r_ev[IDX_ANDI];
  assign ev_slli         = r_ev[IDX_SLLI];
  assign ev_srli         = r_ev[IDX_SRLI];
  assign ev_srai         = r_ev[IDX_SRAI];
  assign ev_add          = r_ev[IDX_ADD];
  assign ev_sub          = r_ev[IDX_SUB];
  assign ev_sll          = r_ev[IDX_SLL];
  assign ev_slt          = r_ev[IDX_SLT];
  assign ev_sltu         = r_ev[IDX_SLTU];
  assign ev_xor          = r_ev[IDX_XOR];
  assign ev_srl          = r_ev[IDX_SRL];
  assign ev_sra          = r_ev[IDX_SRA];
  assign ev_or           = r_ev[IDX_OR];
  assign ev_and          = r_ev[IDX_AND];
  assign ev_rdcycle      = r_ev[IDX_RDCYCLE];
  assign ev_rdcycleh     = r_ev[IDX_RDCYCLEH];
  assign ev_rdinstr      = r_ev[IDX_RDINSTR];
  assign ev_rdinstrh     = r_ev[IDX_RDINSTRH];
  assign ev_ecall_ebreak = r_ev[IDX_ECALL_EBREAK];
  assign ev_getq         = r_ev[IDX_GETQ];
  assign ev_setq         = r_ev[IDX_SETQ];
  assign ev_retirq       = r_ev[IDX_RETIRQ];
  assign ev_maskirq      = r_ev[IDX_MASKIRQ];
  assign ev_waitirq      = r_ev[IDX_WAITIRQ];
  assign ev_timer        = r_ev[IDX_TIMER];
  assign ev_trap         = r_ev[IDX_TRAP];

  assign ev_any    = r_any;
  assign ev_load   = r_load;
  assign ev_store  = r_store;
  assign ev_branch = r_branch;
  assign ev_jump   = r_jump;
  assign ev_alu    = r_alu;
  assign ev_csr    = r_csr;
  assign ev_irqop  = r_irqop;
  assign o_instret = r_instret;

endmodule

// File: tb/tb_rv_instr_evmon.sv
// Directed bench for rv_instr_evmon (CNT_W=8). Flags/events are handled as
// 49-bit vectors in port order; class expectations come from hand-written index ranges.
module tb_rv_instr_evmon;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [48:0] flags = '0;
  logic        dbg = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] next_pc = 32'h4;
  wire  [48:0] ev;
  wire  [6:0]  cls;   // {irqop, csr, alu, jump, branch, store, load}
  wire         any;
  wire  [7:0]  instret;
`ifdef EVMON_DISCONT_EN
  wire         discont;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  rv_instr_evmon #(.CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr_lui(flags[0]), .i_instr_auipc(flags[1]), .i_instr_jal(flags[2]),
    .i_instr_jalr(flags[3]), .i_instr_beq(flags[4]), .i_instr_bne(flags[5]),
    .i_instr_blt(flags[6]), .i_instr_bge(flags[7]), .i_instr_bltu(flags[8]),
    .i_instr_bgeu(flags[9]), .i_instr_lb(flags[10]), .i_instr_lh(flags[11]),
    .i_instr_lw(flags[12]), .i_instr_lbu(flags[13]), .i_instr_lhu(flags[14]),
    .i_instr_sb(flags[15]), .i_instr_sh(flags[16]), .i_instr_sw(flags[17]),
    .i_instr_addi(flags[18]), .i_instr_slti(flags[19]), .i_instr_sltiu(flags[20]),
    .i_instr_xori(flags[21]), .i_instr_ori(flags[22]), .i_instr_andi(flags[23]),
    .i_instr_slli(flags[24]), .i_instr_srli(flags[25]), .i_instr_srai(flags[26]),
    .i_instr_add(flags[27]), .i_instr_sub(flags[28]), .i_instr_sll(flags[29]),
    .i_instr_slt(flags[30]), .i_instr_sltu(flags[31]), .i_instr_xor(flags[32]),
    .i_instr_srl(flags[33]), .i_instr_sra(flags[34]), .i_instr_or(flags[35]),
    .i_instr_and(flags[36]), .i_instr_rdcycle(flags[37]), .i_instr_rdcycleh(flags[38]),
    .i_instr_rdinstr(flags[39]), .i_instr_rdinstrh(flags[40]),
    .i_instr_ecall_ebreak(flags[41]), .i_instr_getq(flags[42]), .i_instr_setq(flags[43]),
    .i_instr_retirq(flags[44]), .i_instr_maskirq(flags[45]), .i_instr_waitirq(flags[46]),
    .i_instr_timer(flags[47]), .i_instr_trap(flags[48]),
    .i_pc(pc), .i_next_pc(next_pc), .i_dbg_next(dbg),
    .ev_lui(ev[0]), .ev_auipc(ev[1]), .ev_jal(ev[2]), .ev_jalr(ev[3]),
    .ev_beq(ev[4]), .ev_bne(ev[5]), .ev_blt(ev[6]), .ev_bge(ev[7]),
    .ev_bltu(ev[8]), .ev_bgeu(ev[9]), .ev_lb(ev[10]), .ev_lh(ev[11]),
    .ev_lw(ev[12]), .ev_lbu(ev[13]), .ev_lhu(ev[14]), .ev_sb(ev[15]),
    .ev_sh(ev[16]), .ev_sw(ev[17]), .ev_addi(ev[18]), .ev_slti(ev[19]),
    .ev_sltiu(ev[20]), .ev_xori(ev[21]), .ev_ori(ev[22]), .ev_andi(ev[23]),
    .ev_slli(ev[24]), .ev_srli(ev[25]), .ev_srai(ev[26]), .ev_add(ev[27]),
    .ev_sub(ev[28]), .ev_sll(ev[29]), .ev_slt(ev[30]), .ev_sltu(ev[31]),
    .ev_xor(ev[32]), .ev_srl(ev[33]), .ev_sra(ev[34]), .ev_or(ev[35]),
    .ev_and(ev[36]), .ev_rdcycle(ev[37]), .ev_rdcycleh(ev[38]), .ev_rdinstr(ev[39]),
    .ev_rdinstrh(ev[40]), .ev_ecall_ebreak(ev[41]), .ev_getq(ev[42]), .ev_setq(ev[43]),
    .ev_retirq(ev[44]), .ev_maskirq(ev[45]), .ev_waitirq(ev[46]), .ev_timer(ev[47]),
    .ev_trap(ev[48]),
    .ev_any(any),
    .ev_load(cls[0]), .ev_store(cls[1]), .ev_branch(cls[2]), .ev_jump(cls[3]),
    .ev_alu(cls[4]), .ev_csr(cls[5]), .ev_irqop(cls[6]),
`ifdef EVMON_DISCONT_EN
    .ev_discont(discont),
`endif
    .o_instret(instret)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle; the model counter follows the strobe driven into that edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n && dbg) exp_cnt = exp_cnt + 8'd1;
    #1;
  endtask

  // Expected class vector for a single flag index, from the instruction class table.
  function automatic logic [6:0] cls_of(input int i);
    logic [6:0] c;
    c = '0;
    if (i >= 10 && i <= 14) c[0] = 1'b1;
    if (i >= 15 && i <= 17) c[1] = 1'b1;
    if (i >= 4  && i <= 9)  c[2] = 1'b1;
    if (i == 2  || i == 3)  c[3] = 1'b1;
    if (i == 0 || i == 1 || (i >= 18 && i <= 36)) c[4] = 1'b1;
    if (i >= 37 && i <= 40) c[5] = 1'b1;
    if (i >= 42 && i <= 47) c[6] = 1'b1;
    return c;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".ev"}, 64'(ev), 64'd0);
    check({tag, ".cls"}, 64'(cls), 64'd0);
    check({tag, ".any"}, 64'(any), 64'd0);
  endtask

  initial begin
    logic [48:0] one;

    // Reset held with a live strobe and add flag.
    rst_n = 1'b0; dbg = 1'b1; flags = '0; flags[27] = 1'b1;
    tick(); tick();
    check_idle("rst");
    check("rst.instret", 64'(instret), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check("rel.ev_add", 64'(ev), 64'(49'd1 << 27));
    check("rel.ev_alu", 64'(cls), 64'h10);
    check("rel.any", 64'(any), 64'd1);
    check("rel.instret", 64'(instret), 64'd1);

    // Strobe gating: flags ignored while dbg is low.
    dbg = 1'b0; flags = '0; flags[12] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("gate.ev_lw", 64'(ev[12]), 64'd0);
      check("gate.ev_load", 64'(cls[0]), 64'd0);
      check("gate.instret", 64'(instret), 64'd1);
    end
    check_idle("gate");

    // Back-to-back beq, sw, jal.
    dbg = 1'b1;
    flags = '0; flags[4] = 1'b1;  tick();
    check("b2b.beq", 64'(ev), 64'(49'd1 << 4));
    check("b2b.branch", 64'(cls), 64'h04);
    flags = '0; flags[17] = 1'b1; tick();
    check("b2b.sw", 64'(ev), 64'(49'd1 << 17));
    check("b2b.store", 64'(cls), 64'h02);
    flags = '0; flags[2] = 1'b1;  tick();
    check("b2b.jal", 64'(ev), 64'(49'd1 << 2));
    check("b2b.jump", 64'(cls), 64'h08);
    check("b2b.instret", 64'(instret), 64'd4);
    dbg = 1'b0; tick();
    check_idle("b2b.after");

    // Multi-flag: getq + rdcycle together.
    dbg = 1'b1; flags = '0; flags[42] = 1'b1; flags[37] = 1'b1;
    tick();
    check("multi.ev", 64'(ev), 64'((49'd1 << 42) | (49'd1 << 37)));
    check("multi.cls", 64'(cls), 64'h60);
    check("multi.any", 64'(any), 64'd1);
    check("multi.instret", 64'(instret), 64'd5);

    // Every flag alone.
    for (int i = 0; i < 49; i++) begin
      one = '0; one[i] = 1'b1;
      flags = one; dbg = 1'b1;
      tick();
      check($sformatf("sweep%0d.ev", i), 64'(ev), 64'(one));
      check($sformatf("sweep%0d.cls", i), 64'(cls), 64'(cls_of(i)));
    end
    check("sweep.instret", 64'(instret), 64'(exp_cnt));
    check("sweep.instret_abs", 64'(instret), 64'd54);

`ifdef EVMON_DISCONT_EN
    flags = '0; dbg = 1'b1;
    pc = 32'h100; next_pc = 32'h104; tick();
    check("disc.seq4", 64'(discont), 64'd0);
    next_pc = 32'h102; tick();
    check("disc.seq2", 64'(discont), 64'd0);
    next_pc = 32'h200; tick();
    check("disc.jump", 64'(discont), 64'd1);
    pc = 32'hFFFF_FFFC; next_pc = 32'h0; tick();
    check("disc.wrap", 64'(discont), 64'd0);
    pc = 32'h100; next_pc = 32'h300; dbg = 1'b0; tick();
    check("disc.nostrobe", 64'(discont), 64'd0);
    pc = 32'h0; next_pc = 32'h4;
    check("disc.instret", 64'(instret), 64'(exp_cnt));
`endif

    // Reset in the middle of a pulse clears asynchronously.
    dbg = 1'b1; flags = '0; flags[27] = 1'b1;
    tick();
    check("mid.pre_add", 64'(ev[27]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("mid.rst");
    check("mid.instret", 64'(instret), 64'd0);
    exp_cnt = 8'd0;
    dbg = 1'b0; flags = '0;
    #2 rst_n = 1'b1;
    tick();
    check("mid.after", 64'(instret), 64'd0);

    // Counter wrap at 8 bits.
    dbg = 1'b1;
    for (int k = 0; k < 255; k++) tick();
    check("wrap.ff", 64'(instret), 64'hFF);
    tick();
    check("wrap.00", 64'(instret), 64'h00);
    check("wrap.model", 64'(instret), 64'(exp_cnt));
    dbg = 1'b0; tick();
    check("wrap.hold", 64'(instret), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
